// File: rtl/vga_pos_pkg.sv
// Shared constants, FSM state type and capture helper for the VGA position loader.
// Contents: display geometry (H_ACTIVE/V_ACTIVE), RAM word offsets from POS_BASE,
// default reset positions, the loader state enum and an unsigned clamp helper.
package vga_pos_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned COUNT_W = 10;

  // Word offsets relative to POS_BASE
  localparam int unsigned OFS_X   = 0;
  localparam int unsigned OFS_Y   = 1;
  localparam int unsigned OFS_CNT = 2;

  localparam logic [DATA_W-1:0] DEF_INIT_X = 16'd400;
  localparam logic [DATA_W-1:0] DEF_INIT_Y = 16'd200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_CAP0,
    ST_ISSUE1,
    ST_CAP1,
    ST_COMMIT,
    ST_WRITE
  } pos_state_e;

  // Unsigned saturation to lim
  function automatic logic [DATA_W-1:0] clamp_pos(input logic [DATA_W-1:0] v,
                                                  input logic [DATA_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/vga_frame_trigger.sv
// Frame trigger: decodes the first blanking line position (hcount==0, vcount==V_ACTIVE)
// and emits a single-cycle combinational pulse on its rising edge.
// Ports:
//   sys_clk, reset     - clock, asynchronous active-high reset
//   hcount, vcount     - VGA counters, synchronous to sys_clk
//   trigger_c          - combinational rising-edge pulse of the decode
module vga_frame_trigger
  import vga_pos_pkg::*;
(
  input  logic               sys_clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] hcount,
  input  logic [COUNT_W-1:0] vcount,
  output logic               trigger_c
);

  logic cond_c;
  logic cond_q;

  assign cond_c = (hcount == '0) && (vcount == COUNT_W'(V_ACTIVE));

  // History register; cleared by reset so a condition already true at release still fires
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cond_q <= 1'b0;
    end else begin
      cond_q <= cond_c;
    end
  end

  assign trigger_c = cond_c & ~cond_q;

endmodule

// File: rtl/vga_pos_loader.sv
// Once per frame, reads obstacle_x and player_y from data RAM into shadow registers,
// commits both positions on the same edge, then writes the new frame count back.
// Ports:
//   sys_clk, reset          - clock, asynchronous active-high reset
//   hcount, vcount          - VGA counters feeding the frame trigger
//   ram_addr, ram_rd_en     - RAM address and read strobe (read data one cycle later)
//   ram_q                   - RAM read data
//   ram_we, ram_wdata       - RAM write strobe and data (frame count write-back)
//   obstacle_x, player_y    - committed positions for the sprite generators
//   frame_cnt               - number of completed commits (wraps)
//   frame_tick              - one-cycle pulse while the new positions become visible
//   busy                    - sequence in progress (state not IDLE)
// Build option: define POS_CLAMP_EN to saturate captured values to the visible area.
module vga_pos_loader
  import vga_pos_pkg::*;
#(
  parameter logic [15:0] POS_BASE = 16'h7FF0,
  parameter logic [15:0] INIT_X   = DEF_INIT_X,
  parameter logic [15:0] INIT_Y   = DEF_INIT_Y
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] hcount,
  input  logic [COUNT_W-1:0] vcount,
  output logic [DATA_W-1:0]  ram_addr,
  output logic               ram_rd_en,
  input  logic [DATA_W-1:0]  ram_q,
  output logic               ram_we,
  output logic [DATA_W-1:0]  ram_wdata,
  output logic [DATA_W-1:0]  obstacle_x,
  output logic [DATA_W-1:0]  player_y,
  output logic [DATA_W-1:0]  frame_cnt,
  output logic               frame_tick,
  output logic               busy
);

  localparam logic [DATA_W-1:0] ADDR_X   = POS_BASE + DATA_W'(OFS_X);
  localparam logic [DATA_W-1:0] ADDR_Y   = POS_BASE + DATA_W'(OFS_Y);
  localparam logic [DATA_W-1:0] ADDR_CNT = POS_BASE + DATA_W'(OFS_CNT);

  logic              trigger_c;
  pos_state_e        state;
  logic [DATA_W-1:0] shx;
  logic [DATA_W-1:0] shy;
  logic [DATA_W-1:0] cap_x_c;
  logic [DATA_W-1:0] cap_y_c;
  logic [DATA_W-1:0] cnt_inc_c;

  vga_frame_trigger u_trigger (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .trigger_c (trigger_c)
  );

  // Capture path into the shadow registers
`ifdef POS_CLAMP_EN
  assign cap_x_c = clamp_pos(ram_q, DATA_W'(H_ACTIVE - 1));
  assign cap_y_c = clamp_pos(ram_q, DATA_W'(V_ACTIVE - 1));
`else
  assign cap_x_c = ram_q;
  assign cap_y_c = ram_q;
`endif

  assign cnt_inc_c = frame_cnt + DATA_W'(1);

  // Sequencer; outputs are loaded with the values belonging to the state being entered
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shx        <= '0;
      shy        <= '0;
      obstacle_x <= INIT_X;
      player_y   <= INIT_Y;
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
      ram_addr   <= ADDR_X;
      ram_rd_en  <= 1'b0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      ram_rd_en  <= 1'b0;
      ram_we     <= 1'b0;
      frame_tick <= 1'b0;
      ram_addr   <= ADDR_X;
      case (state)
        ST_IDLE: begin
          // Triggers arriving in any other state are dropped, never queued
          if (trigger_c) begin
            state     <= ST_ISSUE0;
            ram_rd_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_ISSUE0: state <= ST_CAP0;
        ST_CAP0: begin
          shx       <= cap_x_c;
          state     <= ST_ISSUE1;
          ram_addr  <= ADDR_Y;
          ram_rd_en <= 1'b1;
        end
        ST_ISSUE1: state <= ST_CAP1;
        ST_CAP1: begin
          shy   <= cap_y_c;
          state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          // Both positions update on the same edge so the pair is never torn
          obstacle_x <= shx;
          player_y   <= shy;
          frame_cnt  <= cnt_inc_c;
          state      <= ST_WRITE;
          ram_addr   <= ADDR_CNT;
          ram_we     <= 1'b1;
          ram_wdata  <= cnt_inc_c;
          frame_tick <= 1'b1;
        end
        ST_WRITE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pos_loader.sv
// Scoreboard bench for vga_pos_loader: stimulus pushes the expected commit of each frame,
// a negedge monitor pops and compares whenever frame_tick is seen.
module tb_vga_pos_loader;
  import vga_pos_pkg::*;

  localparam logic [15:0] BASE = 16'h7FF0;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount, vcount;
  logic [15:0] ram_addr, ram_q, ram_wdata, obstacle_x, player_y, frame_cnt;
  logic        ram_rd_en, ram_we, frame_tick, busy;

  always #5 sys_clk = ~sys_clk;

  vga_pos_loader #(.POS_BASE(BASE), .INIT_X(16'd400), .INIT_Y(16'd200)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .ram_addr   (ram_addr),
    .ram_rd_en  (ram_rd_en),
    .ram_q      (ram_q),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .obstacle_x (obstacle_x),
    .player_y   (player_y),
    .frame_cnt  (frame_cnt),
    .frame_tick (frame_tick),
    .busy       (busy)
  );

  // Synchronous RAM model, one-cycle read latency; bench preload through a side port
  logic [15:0] mem [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0, pre_data = '0;
  always @(posedge sys_clk) begin
    ram_q <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] cnt;
    int unsigned tick_cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the outputs should show between frames
  logic [15:0] cur_x = 16'd400, cur_y = 16'd200, model_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_x(input logic [15:0] raw);
`ifdef POS_CLAMP_EN
    return (raw > 16'd639) ? 16'd639 : raw;
`else
    return raw;
`endif
  endfunction

  function automatic logic [15:0] model_y(input logic [15:0] raw);
`ifdef POS_CLAMP_EN
    return (raw > 16'd479) ? 16'd479 : raw;
`else
    return raw;
`endif
  endfunction

  // Monitor: every frame_tick must match the oldest expected commit
  always @(negedge sys_clk) begin
    if (!reset) begin
      if (ram_we && !frame_tick) check("write_without_tick", 32'(ram_we), 32'd0);
      if (frame_tick) begin
        if (sb.size() == 0) begin
          check("tick_without_frame", 32'(frame_tick), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("commit_x",     32'(obstacle_x), 32'(mon_e.x));
          check("commit_y",     32'(player_y),   32'(mon_e.y));
          check("commit_cnt",   32'(frame_cnt),  32'(mon_e.cnt));
          check("tick_latency", cyc,             mon_e.tick_cyc);
          check("wb_we",        32'(ram_we),     32'd1);
          check("wb_addr",      32'(ram_addr),   32'(BASE + 16'd2));
          check("wb_data",      32'(ram_wdata),  32'(mon_e.cnt));
        end
      end
    end
  end

  task automatic idle_video();
    hcount = 10'($urandom_range(1, 799));
    vcount = 10'($urandom_range(0, 524));
  endtask

  task automatic ram_load(input logic [15:0] a, input logic [15:0] d);
    @(negedge sys_clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge sys_clk);
    pre_we = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge sys_clk);
    if (sb.size() != 0) begin
      check("tick_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // One frame: raw RAM values, optional retrigger in ISSUE1, optional reset in CAP1
  task automatic run_frame(input logic [15:0] rx, input logic [15:0] ry,
                           input bit repulse, input bit abort);
    int unsigned k;
    logic [15:0] nx, ny, a_exp;
    ram_load(BASE, rx);
    ram_load(BASE + 16'd1, ry);
    @(negedge sys_clk);
    k = cyc;
    hcount = 10'd0; vcount = 10'd480;
    nx = model_x(rx); ny = model_y(ry);
    if (!abort) begin
      model_cnt = model_cnt + 16'd1;
      sb.push_back('{x: nx, y: ny, cnt: model_cnt, tick_cyc: k + 6});
    end
    // s counts sys_clk cycles after the trigger edge
    for (int s = 0; s <= 6; s++) begin
      @(negedge sys_clk);
      if (s == 1) idle_video();
      if (repulse && s == 2) begin hcount = 10'd0; vcount = 10'd480; end
      if (repulse && s == 3) idle_video();
      a_exp = (s == 2) ? BASE + 16'd1 : (s == 5) ? BASE + 16'd2 : BASE;
      check("busy",    32'(busy),       32'(s <= 5));
      check("rd_en",   32'(ram_rd_en),  32'(s == 0 || s == 2));
      check("addr",    32'(ram_addr),   32'(a_exp));
      check("pos_x",   32'(obstacle_x), 32'((s >= 5) ? nx : cur_x));
      check("pos_y",   32'(player_y),   32'((s >= 5) ? ny : cur_y));
      if (abort && s == 3) begin
        reset = 1'b1;
        break;
      end
    end
    if (!abort) begin
      wait_drain();
      cur_x = nx; cur_y = ny;
      check("ram_cnt_wb", 32'(mem[BASE + 16'd2]), 32'(model_cnt));
      check("frame_cnt",  32'(frame_cnt),         32'(model_cnt));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"},     32'(obstacle_x), 32'd400);
    check({tag, "_y"},     32'(player_y),   32'd200);
    check({tag, "_cnt"},   32'(frame_cnt),  32'd0);
    check({tag, "_tick"},  32'(frame_tick), 32'd0);
    check({tag, "_we"},    32'(ram_we),     32'd0);
    check({tag, "_rd"},    32'(ram_rd_en),  32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] saved_wb;
    reset = 1'b1;
    hcount = 10'd5; vcount = 10'd0;
    repeat (3) @(negedge sys_clk);
    check_reset_values("in_reset");
    check("in_reset_addr", 32'(ram_addr), 32'(BASE));
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_reset_values("after_reset");

    // Single frame, then two more with new RAM contents
    run_frame(16'd120, 16'd300, 1'b0, 1'b0);
    run_frame(16'd10,  16'd20,  1'b0, 1'b0);
    run_frame(16'd639, 16'd479, 1'b0, 1'b0);
    check("three_frames_cnt", 32'(frame_cnt), 32'(model_cnt));

    // Retrigger while busy must be ignored
    run_frame(16'd55, 16'd66, 1'b1, 1'b0);
    repeat (10) @(negedge sys_clk);

    // Reset during CAP1 aborts without commit or write-back
    saved_wb = mem[BASE + 16'd2];
    run_frame(16'd77, 16'd88, 1'b0, 1'b1);
    idle_video();
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
    cur_x = 16'd400; cur_y = 16'd200; model_cnt = '0;
    repeat (10) @(negedge sys_clk);
    check_reset_values("abort");
    check("abort_no_write", 32'(mem[BASE + 16'd2]), 32'(saved_wb));

    // Reset released with the trigger condition already true fires on the next edge
    ram_load(BASE, 16'd321);
    ram_load(BASE + 16'd1, 16'd123);
    @(negedge sys_clk);
    reset = 1'b1; hcount = 10'd0; vcount = 10'd480;
    @(negedge sys_clk);
    reset = 1'b0;
    model_cnt = model_cnt + 16'd1;
    sb.push_back('{x: model_x(16'd321), y: model_y(16'd123), cnt: model_cnt, tick_cyc: cyc + 6});
    @(negedge sys_clk);
    idle_video();
    wait_drain();
    cur_x = model_x(16'd321); cur_y = model_y(16'd123);
    check("release_trig_x", 32'(obstacle_x), 32'(cur_x));

    // Out-of-range values (saturated only in the clamping build)
    run_frame(16'd1000, 16'hFFFF, 1'b0, 1'b0);

    // Randomized frames with random gaps
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 4)) begin
        @(negedge sys_clk);
        idle_video();
      end
      if ($urandom_range(0, 1) == 1)
        run_frame(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      else
        run_frame(16'($urandom_range(0, 700)), 16'($urandom_range(0, 520)), 1'b0, 1'b0);
    end

    // Counter wrap: preset to all ones, one frame returns it to zero
    @(negedge sys_clk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge sys_clk);
    release dut.frame_cnt;
    model_cnt = 16'hFFFF;
    run_frame(16'd42, 16'd24, 1'b0, 1'b0);
    check("wrap_cnt", 32'(frame_cnt), 32'd0);
    check("wrap_ram", 32'(mem[BASE + 16'd2]), 32'd0);

    repeat (5) @(negedge sys_clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pos_loader.md
VGA_POS_LOADER -- requirements
Module: vga_pos_loader

Interface
REQ-001 The block SHALL have parameter POS_BASE, default 16'h7FF0, which is the RAM word address of obstacle_x; player_y is at +1 and the frame counter write-back is at +2.
REQ-002 The block SHALL have parameter INIT_X, default 16'd400, which is the reset value of obstacle_x.
REQ-003 The block SHALL have parameter INIT_Y, default 16'd200, which is the reset value of player_y.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the 50 MHz clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have ports hcount and vcount, input, 10 bits each: VGA counters from vga_control, synchronous to sys_clk.
REQ-007 The block SHALL have port ram_addr, output, 16 bits: data-RAM port address.
REQ-008 The block SHALL have port ram_rd_en, output, 1 bit: read strobe.
REQ-009 The block SHALL have port ram_q, input, 16 bits: read data, valid one cycle after the address is presented.
REQ-010 The block SHALL have ports ram_we, output, 1 bit (write strobe), and ram_wdata, output, 16 bits (write data).
REQ-011 The block SHALL have ports obstacle_x and player_y, output, 16 bits each: committed positions that feed the sprite generators.
REQ-012 The block SHALL have port frame_cnt, output, 16 bits: count of completed commits.
REQ-013 The block SHALL have ports frame_tick, output, 1 bit (one-cycle pulse marking that new positions are visible), and busy, output, 1 bit (FSM not in IDLE).

Function
REQ-014 The trigger condition SHALL be hcount==0 && vcount==480; the trigger SHALL be its rising edge (condition AND NOT registered condition), so each frame produces exactly one trigger although the condition holds for 2 sys_clk cycles.
REQ-015 The FSM SHALL have the states IDLE, ISSUE0, CAP0, ISSUE1, CAP1, COMMIT and WRITE, with transitions IDLE->ISSUE0 on trigger and every other state advancing unconditionally in the order listed, with WRITE->IDLE.
REQ-016 The outputs SHALL be driven as follows: ISSUE0 drives ram_addr=POS_BASE with ram_rd_en=1; ISSUE1 drives ram_addr=POS_BASE+1 with ram_rd_en=1; CAP0 and CAP1 sample ram_q into the shadow registers shx and shy respectively; all other states drive ram_rd_en=0.
REQ-017 At the edge leaving COMMIT, the block SHALL update obstacle_x and player_y from the shadow registers in the same edge (no half-updated pair visible) and SHALL increment frame_cnt, wrapping 16'hFFFF->0.
REQ-018 In WRITE the block SHALL assert frame_tick=1 and ram_we=1, with ram_addr=POS_BASE+2 and ram_wdata equal to the new frame_cnt; ram_we SHALL be 0 in all other states.
REQ-019 Latency SHALL be as follows: if the trigger is sampled at edge E0, new positions are visible after E5 and frame_tick is high from E5 to E6.
REQ-020 A trigger that occurs while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 ram_addr SHALL equal POS_BASE in IDLE, CAP0, CAP1 and COMMIT.
REQ-022 busy SHALL be 1 in every state except IDLE.

Reset
REQ-023 On reset the block SHALL set: state=IDLE, obstacle_x=INIT_X, player_y=INIT_Y, shadow registers=0, frame_cnt=0, frame_tick=0, ram_we=0, ram_rd_en=0, busy=0, trigger history register=0.
REQ-024 Reset asserted mid-sequence SHALL abort the sequence with no commit and no write.
REQ-025 A reset released while the trigger condition is true SHALL produce a trigger on the next edge.

Configuration
REQ-026 When POS_CLAMP_EN is defined, values SHALL be clamped at capture: shx = min(ram_q, 639) and shy = min(ram_q, 479), with the comparison unsigned.
REQ-027 When POS_CLAMP_EN is undefined, ram_q SHALL be captured unmodified.

Structure
REQ-028 A package vga_pos_pkg SHALL hold the state enum, H_ACTIVE=640, V_ACTIVE=480, the offset constants (0, 1, 2) and the default INIT values.
REQ-029 The block SHALL contain one sub-module, vga_frame_trigger, which owns the condition decode and edge detect.

Verification
REQ-030 The bench SHALL preload RAM with [POS_BASE]=120 and [POS_BASE+1]=300, then drive vcount=480 with hcount=0 for 2 cycles; required response: exactly one sequence, obstacle_x=120 and player_y=300 after E5, frame_tick high for 1 cycle, and RAM[POS_BASE+2]=1.
REQ-031 The bench SHALL run 3 frames with RAM changed between frames; required response: frame_cnt=3 and the outputs track each frame's values.
REQ-032 The bench SHALL assert reset during CAP1; required response: outputs revert to 400/200 with no write observed.
REQ-033 The bench SHALL pulse the trigger condition again while in ISSUE1; required response: only one commit occurs and frame_cnt increments by 1.
REQ-034 With POS_CLAMP_EN defined, the bench SHALL load [POS_BASE]=1000 and [POS_BASE+1]=16'hFFFF; required response: 639 and 479.
REQ-035 The bench SHALL preset frame_cnt to 16'hFFFF and run one frame; required response: frame_cnt=0 and RAM[POS_BASE+2]=0.
